// File: rtl/rr_grant_ctrl.sv
// Four-way round-robin arbiter with a bounded hold time per grant.
// The winner is held as a 2-bit index and presented as a one-hot grant.
module rr_grant_ctrl #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          r_state;
  logic [1:0]      r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_gnt;
  logic [1:0]      r_gnt_idx;
  logic            r_gnt_valid;
  logic            r_timeout;

  logic            w_found;
  logic [1:0]      w_sel;
  logic            w_hold_req;
  logic            w_at_limit;

  // First requester at or after the priority pointer, wrapping mod 4.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!w_found && req[r_ptr + 2'(i)]) begin
        w_found = 1'b1;
        w_sel   = r_ptr + 2'(i);
      end
    end
  end

  assign w_hold_req = req[r_gnt_idx];
  assign w_at_limit = (r_cnt == CW'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state     <= GRANT;
            r_gnt_idx   <= w_sel;
            r_gnt_valid <= 1'b1;
            r_gnt       <= 4'b0001 << w_sel;
            r_cnt       <= CW'(1);
          end
        end
        GRANT: begin
          // Counter only advances below the limit, so it saturates at MAX_HOLD.
          if (!w_hold_req || w_at_limit) begin
            r_state     <= IDLE;
            r_gnt_valid <= 1'b0;
            r_gnt       <= '0;
            r_ptr       <= r_gnt_idx + 2'd1;
            r_cnt       <= '0;
            r_timeout   <= w_hold_req;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl: two instances (MAX_HOLD 16 and 2) checked every
// cycle against an abstract arbitration model, plus literal directed checks.
module tb_rr_grant_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_a = 4'b0000;
  logic [3:0] req_b = 4'b0000;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic       val_a, val_b;
  logic       to_a, to_b;

  int checks = 0;
  int errors = 0;

  rr_grant_ctrl #(.MAX_HOLD(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a), .timeout(to_a)
  );

  rr_grant_ctrl #(.MAX_HOLD(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b), .timeout(to_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit busy;
    int owner;
    int ptr;
    int tenure;
    bit tout;
  } mdl_t;

  localparam mdl_t MDL_RST = '{busy: 1'b0, owner: 0, ptr: 0, tenure: 0, tout: 1'b0};

  mdl_t ma = MDL_RST;
  mdl_t mb = MDL_RST;

  function automatic mdl_t step(mdl_t s, logic [3:0] r, int maxh);
    mdl_t n;
    bit found;
    n      = s;
    n.tout = 1'b0;
    found  = 1'b0;
    if (!s.busy) begin
      for (int k = 0; k < 4; k++) begin
        if (!found && r[(s.ptr + k) % 4]) begin
          found    = 1'b1;
          n.busy   = 1'b1;
          n.owner  = (s.ptr + k) % 4;
          n.tenure = 1;
        end
      end
    end else if (!r[s.owner] || s.tenure >= maxh) begin
      n.busy   = 1'b0;
      n.ptr    = (s.owner + 1) % 4;
      n.tenure = 0;
      n.tout   = r[s.owner];
    end else begin
      n.tenure = s.tenure + 1;
    end
    return n;
  endfunction

  function automatic logic [3:0] mgnt(mdl_t s);
    return s.busy ? (4'b0001 << s.owner) : 4'b0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Abstract model advances on every active edge and on async reset.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ma = MDL_RST;
        mb = MDL_RST;
      end else begin
        ma = step(ma, req_a, 16);
        mb = step(mb, req_b, 2);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      chk("a_gnt",   32'(gnt_a), 32'(mgnt(ma)));
      chk("a_idx",   32'(idx_a), 32'(ma.owner));
      chk("a_valid", 32'(val_a), 32'(ma.busy));
      chk("a_tout",  32'(to_a),  32'(ma.tout));
      chk("b_gnt",   32'(gnt_b), 32'(mgnt(mb)));
      chk("b_idx",   32'(idx_b), 32'(mb.owner));
      chk("b_valid", 32'(val_b), 32'(mb.busy));
      chk("b_tout",  32'(to_b),  32'(mb.tout));
    end
  end

  logic [3:0] rot_gnt [13];
  logic       rot_to  [13];

  initial begin
    rot_gnt = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    rot_to  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset held with all requesting
    req_a = 4'b1111;
    tick; tick;
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_idx", 32'(idx_a), 32'h0);
    chk("rst_tout", 32'(to_a), 32'h0);
    chk("rst_valid", 32'(val_a), 32'h0);
    rst_n = 1'b1;
    tick;
    chk("rst_rel_gnt", 32'(gnt_a), 32'h1);
    req_a = 4'b0000;
    tick;
    chk("rel_gnt", 32'(gnt_a), 32'h0);
    tick;

    // Single requester held three cycles (ptr now 1)
    req_a = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("single_gnt", 32'(gnt_a), 32'h4);
    end
    req_a = 4'b0000;
    tick;
    chk("single_drop", 32'(gnt_a), 32'h0);
    chk("single_keep_idx", 32'(idx_a), 32'h2);
    req_a = 4'b0100;
    tick;
    chk("single_again", 32'(gnt_a), 32'h4);
    chk("single_again_idx", 32'(idx_a), 32'h2);
    req_a = 4'b0000;
    tick;

    // Pointer wrap: grant 1 released, then 0011 must pick 0
    req_a = 4'b0010;
    tick;
    chk("ptr_g1", 32'(gnt_a), 32'h2);
    req_a = 4'b0000;
    tick;
    req_a = 4'b0011;
    tick;
    chk("ptr_wrap", 32'(gnt_a), 32'h1);
    req_a = 4'b0000;
    tick;

    // No pre-emption
    req_a = 4'b0001;
    tick;
    chk("nopre_g0", 32'(gnt_a), 32'h1);
    req_a = 4'b1001;
    tick;
    chk("nopre_hold1", 32'(gnt_a), 32'h1);
    tick;
    chk("nopre_hold2", 32'(gnt_a), 32'h1);
    req_a = 4'b1000;
    tick;
    chk("nopre_gap", 32'(gnt_a), 32'h0);
    tick;
    chk("nopre_g3", 32'(gnt_a), 32'h8);

    // Async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt_a), 32'h0);
    chk("async_valid", 32'(val_a), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick;
    chk("async_regrant", 32'(gnt_a), 32'h8);
    chk("async_regrant_idx", 32'(idx_a), 32'h3);
    req_a = 4'b0000;
    tick;

    // Full-length hold then forced release; timed-out requester loses priority
    req_a = 4'b0001;
    tick;
    chk("long_start", 32'(gnt_a), 32'h1);
    repeat (15) tick;
    chk("long_last", 32'(gnt_a), 32'h1);
    req_a = 4'b0011;
    tick;
    chk("long_timeout_gnt", 32'(gnt_a), 32'h0);
    chk("long_timeout_pulse", 32'(to_a), 32'h1);
    tick;
    chk("long_next_gnt", 32'(gnt_a), 32'h2);
    chk("long_pulse_gone", 32'(to_a), 32'h0);
    req_a = 4'b0000;
    tick;

    // Rotation with MAX_HOLD=2 on instance B
    req_b = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      tick;
      chk("rot_gnt", 32'(gnt_b), 32'(rot_gnt[i]));
      chk("rot_tout", 32'(to_b), 32'(rot_to[i]));
    end
    req_b = 4'b0000;
    tick; tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
